conv3d_tap_accumulator: RTL and testbench

//  Downstream stage of the 3D-conv datapath. Consumes the per-tap product stream
//  (one input*weight product per beat) and sums TAPS = KD*KH*KW*CIN products per

---
 rtl/conv3d_tap_accumulator.sv | 185 ++++++++++++++++++
 tb/tb_conv3d_tap_accumulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3d_tap_accumulator.sv
// ---------------------------------------------------------------------------
// conv3d_tap_accumulator
//
// Purpose:
//   Last stage of the 3D-conv datapath. It sums TAPS signed tap products per
//   output voxel, starting from a per-voxel bias. The finished sum is rounded
//   half toward +inf, arithmetically shifted right by SHIFT and saturated to
//   DATA_W bits. The result is then held in a one-entry output register with
//   a last-voxel flag. The next voxel can accumulate while the previous result
//   waits for the consumer. Only the final tap of a voxel stalls, because it
//   needs the output register to be free.
//
// Parameters:
//   DATA_W   width of prod_data, bias_data, output_data (signed)
//   ACC_W    accumulator width, >= DATA_W + clog2(TAPS+1)
//   TAPS     products per voxel (>= 2)
//   OUT_VOL  voxels per output volume (period of last_out)
//   SHIFT    arithmetic right shift of the final sum (0 = none)
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous reset, active low
//   valid_in     in   1       prod_data (and bias_data on tap 0) valid
//   ready_in     out  1       a tap can be accepted this cycle
//   prod_data    in   DATA_W  signed tap product
//   bias_data    in   DATA_W  signed bias, sampled on tap 0 only
//   valid_out    out  1       output_data holds a finished voxel
//   ready_out    in   1       downstream accepts the output this cycle
//   output_data  out  DATA_W  rounded, shifted, saturated voxel result
//   last_out     out  1       result is voxel OUT_VOL-1 of the volume
//   sat_flag     out  1       sticky: some result saturated since reset
//
// Operating states (implicit in tap_cnt / valid_out):
//   state     | meaning
//   ACC       | accumulating, output register empty
//   ACC+FULL  | accumulating, result held for downstream
//   STALL     | final tap waiting, result still held (ready_in low)
// ---------------------------------------------------------------------------
module conv3d_tap_accumulator #(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 48,
  parameter int TAPS    = 315,
  parameter int OUT_VOL = 64,
  parameter int SHIFT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] prod_data,
  input  logic [DATA_W-1:0] bias_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] output_data,
  output logic              last_out,
  output logic              sat_flag
);

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int VOX_W = (OUT_VOL > 1) ? $clog2(OUT_VOL) : 1;
  localparam int EXT_W = ACC_W - DATA_W;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [VOX_W-1:0] VOX_LAST = VOX_W'(OUT_VOL - 1);

  // Rounding is done one bit wider than the accumulator, so adding half an
  // LSB to a near-full-scale sum cannot wrap. The shift form yields 0 when
  // SHIFT is 0, which avoids a negative shift amount.
  localparam logic signed [ACC_W:0] RND_ADD =
    ((ACC_W + 1)'(1) << SHIFT) >> 1;

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(EXT_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(EXT_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [TAP_W-1:0]        tap_cnt;
  logic [VOX_W-1:0]        vox_cnt;
  logic signed [ACC_W-1:0] acc;

  logic                    last_tap;
  logic                    first_tap;
  logic                    accept;
  logic                    load;
  logic                    drain;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum_next;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W:0]   sum_rnd;
  logic signed [ACC_W:0]   sum_shr;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [DATA_W-1:0]       result;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign last_tap  = (tap_cnt == TAP_LAST);
  assign first_tap = (tap_cnt == '0);

  // Only the final tap needs the output register. Earlier taps keep flowing
  // while a result is held.
  assign ready_in = !(last_tap && valid_out && !ready_out);
  assign accept   = valid_in && ready_in;
  assign load     = accept && last_tap;
  assign drain    = valid_out && ready_out;

  // -------------------------------------------------------------------------
  // Accumulate, round, shift, saturate
  // -------------------------------------------------------------------------
  assign prod_ext = {{EXT_W{prod_data[DATA_W-1]}}, prod_data};
  assign bias_ext = {{EXT_W{bias_data[DATA_W-1]}}, bias_data};

  // On tap 0 the sum starts from the bias rather than from the stale acc.
  // For that reason the register needs no clear between voxels.
  assign sum_next = first_tap ? (bias_ext + prod_ext) : (acc + prod_ext);

  assign sum_wide = {sum_next[ACC_W-1], sum_next};
  assign sum_rnd  = sum_wide + RND_ADD;
  assign sum_shr  = sum_rnd >>> SHIFT;

  assign sat_hi = (sum_shr > SAT_MAX);
  assign sat_lo = (sum_shr < SAT_MIN);

  always_comb begin
    result = sum_shr[DATA_W-1:0];
    if (sat_hi) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (sat_lo) begin
      result = SAT_MIN[DATA_W-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Tap counter and accumulator
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
      acc     <= '0;
    end else if (accept) begin
      acc <= sum_next;
      if (last_tap) begin
        tap_cnt <= '0;
      end else begin
        tap_cnt <= tap_cnt + TAP_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register and volume position
  // -------------------------------------------------------------------------
  // A load in the same cycle as a drain replaces the departing result, and
  // valid_out stays high. While a result is held and not drained, nothing
  // here changes, so output_data and last_out are stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      output_data <= '0;
      last_out    <= 1'b0;
      vox_cnt     <= '0;
      sat_flag    <= 1'b0;
    end else begin
      if (load) begin
        valid_out   <= 1'b1;
        output_data <= result;
        last_out    <= (vox_cnt == VOX_LAST);
        if (vox_cnt == VOX_LAST) begin
          vox_cnt <= '0;
        end else begin
          vox_cnt <= vox_cnt + VOX_W'(1);
        end
        if (sat_hi || sat_lo) begin
          sat_flag <= 1'b1;
        end
      end else if (drain) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv3d_tap_accumulator.sv
module tb_conv3d_tap_accumulator;

  localparam int DATA_W  = 32;
  localparam int ACC_W   = 48;
  localparam int TAPS    = 4;
  localparam int OUT_VOL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic ready_out = 1'b1;
  logic [DATA_W-1:0] prod_data = '0;
  logic [DATA_W-1:0] bias_data = '0;

  logic              ready_in0, valid_out0, last0, sat0;
  logic [DATA_W-1:0] out0;
  logic              ready_in4, valid_out4, last4, sat4;
  logic [DATA_W-1:0] out4;

  always #5 clk = ~clk;

  conv3d_tap_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .TAPS(TAPS), .OUT_VOL(OUT_VOL), .SHIFT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in0),
    .prod_data(prod_data), .bias_data(bias_data), .valid_out(valid_out0),
    .ready_out(ready_out), .output_data(out0), .last_out(last0), .sat_flag(sat0)
  );

  conv3d_tap_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .TAPS(TAPS), .OUT_VOL(OUT_VOL), .SHIFT(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in4),
    .prod_data(prod_data), .bias_data(bias_data), .valid_out(valid_out4),
    .ready_out(ready_out), .output_data(out4), .last_out(last4), .sat_flag(sat4)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              sat;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];

  int n_vec = 0;
  int n_err = 0;

  int     mtap = 0;
  int     mvox = 0;
  longint msum = 0;
  logic   msat0 = 1'b0;
  logic   msat4 = 1'b0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: round half toward +inf, arithmetic shift, clamp to DATA_W.
  function automatic logic [DATA_W-1:0] ref_out(input longint sum, input int sh,
                                                output logic sat);
    longint r;
    r = sum;
    if (sh > 0) r = r + (64'sd1 <<< (sh - 1));
    r = r >>> sh;
    sat = 1'b0;
    if (r > 64'sd2147483647) begin
      r = 64'sd2147483647;
      sat = 1'b1;
    end else if (r < -64'sd2147483648) begin
      r = -64'sd2147483648;
      sat = 1'b1;
    end
    return r[DATA_W-1:0];
  endfunction

  // Output monitor: an output transfers when valid & ready at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_out0 && ready_out) begin
        if (q0.size() == 0) begin
          chk("s0_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          chk("s0_data", out0, e.data);
          chk("s0_last", {31'd0, last0}, {31'd0, e.last});
          chk("s0_sat", {31'd0, sat0}, {31'd0, e.sat});
        end
      end
      if (valid_out4 && ready_out) begin
        if (q4.size() == 0) begin
          chk("s4_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          chk("s4_data", out4, e.data);
          chk("s4_last", {31'd0, last4}, {31'd0, e.last});
          chk("s4_sat", {31'd0, sat4}, {31'd0, e.sat});
        end
      end
    end
  end

  // Drive one tap and return #1 after the edge that accepted it.
  task automatic tap(input logic signed [DATA_W-1:0] b,
                     input logic signed [DATA_W-1:0] p);
    exp_t e;
    logic s;
    int   w;
    valid_in  = 1'b1;
    bias_data = b;
    prod_data = p;
    w = 0;
    @(negedge clk);
    while (!ready_in0) begin
      w++;
      if (w > 50) begin
        n_err++;
        $display("FAIL tap_wait observed=ready_in stuck low expected=accept within 50 cycles");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "tap accept timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (mtap == 0) msum = longint'(b) + longint'(p);
    else           msum = msum + longint'(p);
    if (mtap == TAPS - 1) begin
      e.last = (mvox == OUT_VOL - 1);
      e.data = ref_out(msum, 0, s);
      msat0  = msat0 | s;
      e.sat  = msat0;
      q0.push_back(e);
      e.data = ref_out(msum, 4, s);
      msat4  = msat4 | s;
      e.sat  = msat4;
      q4.push_back(e);
      mvox = (mvox + 1) % OUT_VOL;
      mtap = 0;
    end else begin
      mtap++;
    end
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", {31'd0, valid_out0}, 32'd0);
    chk("rst_data", out0, 32'd0);
    chk("rst_last", {31'd0, last0}, 32'd0);
    chk("rst_sat0", {31'd0, sat0}, 32'd0);
    chk("rst_sat4", {31'd0, sat4}, 32'd0);
    chk("rst_ready_in", {31'd0, ready_in0}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mtap = 0;
    mvox = 0;
    msat0 = 1'b0;
    msat4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "global timeout");
  end

  initial begin
    logic signed [DATA_W-1:0] t3_prod [4][4];
    logic signed [DATA_W-1:0] t3_exp  [4];

    // Reset state
    @(posedge clk);
    #1;
    do_reset();

    // 1. bias 10, prods 1..4, latency 1, single-cycle valid
    tap(10, 1);
    tap(10, 2);
    tap(10, 3);
    chk("t1_valid_before", {31'd0, valid_out0}, 32'd0);
    tap(10, 4);
    chk("t1_valid_after", {31'd0, valid_out0}, 32'd1);
    chk("t1_data", out0, 32'd20);
    idle(1);
    chk("t1_valid_drop", {31'd0, valid_out0}, 32'd0);
    idle(2);

    // 2. positive and negative saturation, sticky flag
    repeat (4) tap(0, 32'h7FFF_FFFF);
    chk("t2_pos_sat", out0, 32'h7FFF_FFFF);
    chk("t2_flag", {31'd0, sat0}, 32'd1);
    repeat (4) tap(0, 32'h8000_0000);
    chk("t2_neg_sat", out0, 32'h8000_0000);
    idle(2);
    chk("t2_flag_sticky", {31'd0, sat0}, 32'd1);

    // 3. rounding with SHIFT=4: sums 24, -24, 8, 7 -> 2, -1, 1, 0
    t3_prod[0] = '{6, 6, 6, 6};
    t3_prod[1] = '{-6, -6, -6, -6};
    t3_prod[2] = '{2, 2, 2, 2};
    t3_prod[3] = '{1, 2, 3, 1};
    t3_exp     = '{2, -1, 1, 0};
    for (int v = 0; v < 4; v++) begin
      for (int t = 0; t < 4; t++) tap(0, t3_prod[v][t]);
      chk($sformatf("t3_round_%0d", v), out4, t3_exp[v]);
    end
    idle(2);

    // 4. backpressure: 3 taps flow, the 4th stalls, then drain+load together
    ready_out = 1'b0;
    repeat (4) tap(0, 1);
    for (int t = 0; t < 3; t++) tap(0, 2);
    chk("t4_taps_flowed", {31'd0, valid_out0}, 32'd1);
    valid_in  = 1'b1;
    bias_data = 0;
    prod_data = 2;
    repeat (3) begin
      @(negedge clk);
      chk("t4_ready_in_low", {31'd0, ready_in0}, 32'd0);
      chk("t4_hold_data", out0, 32'd4);
      chk("t4_hold_valid", {31'd0, valid_out0}, 32'd1);
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    tap(0, 2);
    chk("t4_new_valid", {31'd0, valid_out0}, 32'd1);
    chk("t4_new_data", out0, 32'd8);
    idle(3);

    // 5. six voxels from a clean volume: last_out on outputs 3 and 6
    do_reset();
    for (int v = 0; v < 6; v++) begin
      for (int t = 0; t < 4; t++) tap(v, t + 1);
      chk($sformatf("t5_last_%0d", v), {31'd0, last0}, (v % 3 == 2) ? 32'd1 : 32'd0);
    end
    idle(3);

    // 6. reset mid-voxel discards the partial sum
    tap(0, 100);
    tap(0, 100);
    do_reset();
    repeat (4) tap(0, 5);
    chk("t6_no_residue", out0, 32'd20);
    idle(4);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
